// File: rtl/tank_vertical_motion_pkg.sv
// Shared types and constants for the tank vertical-motion and floor-collision stages.
package tank_motion_pkg;

   typedef enum logic [1:0] {
      TERR_FLAT = 2'b00,
      TERR_DOWN = 2'b01,
      TERR_UP   = 2'b10,
      TERR_RSVD = 2'b11
   } terrain_t;

   typedef enum logic [1:0] {
      MS_GROUND = 2'd0,
      MS_RAMP   = 2'd1,
      MS_FALL   = 2'd2
   } mstate_t;

   typedef enum logic [1:0] {
      DIR_STILL = 2'd0,
      DIR_LEFT  = 2'd1,
      DIR_RIGHT = 2'd2
   } dir_t;

   localparam logic [9:0] LOW_Y      = 10'd400;
   localparam logic [9:0] HIGH_Y     = 10'd380;
   localparam logic [9:0] CLIMB_STEP = 10'd1;
   localparam logic [3:0] GRAVITY    = 4'd1;
   localparam logic [3:0] MAX_FALL_V = 4'd6;

   function automatic logic is_level(input logic [9:0] y);
      return (y == LOW_Y) || (y == HIGH_Y);
   endfunction

endpackage

// File: rtl/tank_vertical_motion_if.sv
// Per-frame terrain/position inputs and vertical-motion outputs of the tank.
interface tank_vertical_motion_if;
   logic [9:0] firstX;
   logic [1:0] floor;
   logic       spawn_req;
   logic [9:0] spawn_y;
   logic [9:0] firstY;
   logic       on_high;
   logic       airborne;
   logic [1:0] mstate;

   modport master (
      output firstX, floor, spawn_req, spawn_y,
      input  firstY, on_high, airborne, mstate
   );

   modport slave (
      input  firstX, floor, spawn_req, spawn_y,
      output firstY, on_high, airborne, mstate
   );
endinterface

// File: rtl/tank_vertical_motion_x_dir_detect.sv
// Horizontal travel direction: current X against the X seen on the previous frame.
module x_dir_detect
   import tank_motion_pkg::*;
(
   input  logic       clk,
   input  logic [9:0] x,
   output dir_t       dir
);
   logic [9:0] prev_x;

   // Reloading every frame also covers reset and spawn, which both restart from the current X.
   always_ff @(posedge clk) begin
      prev_x <= x;
   end

   always_comb begin
      if (x > prev_x)      dir = DIR_RIGHT;
      else if (x < prev_x) dir = DIR_LEFT;
      else                 dir = DIR_STILL;
   end
endmodule

// File: rtl/tank_vertical_motion.sv
// Tank vertical position: ramp following, level resting and falling.
// Build option TANK_GRAVITY_EN selects accelerating fall instead of constant-speed fall.
//
// state     | meaning
// MS_GROUND | resting on LOW_Y or HIGH_Y
// MS_RAMP   | following a ramp, Y within [HIGH_Y..LOW_Y]
// MS_FALL   | airborne, dropping toward LOW_Y
module tank_vertical_motion
   import tank_motion_pkg::*;
(
   input  logic             frame_clk,
   input  logic             Reset,
   tank_vertical_motion_if.slave bus
);
   mstate_t    state, state_nxt;
   logic [9:0] y, y_nxt;
   dir_t       dir;
   terrain_t   terr;
   logic       ramp_cls, climb, descend;
   logic [9:0] y_up, y_dn, y_fall, spawn_c;
   logic [10:0] y_w, y_sum;
   logic [3:0] fall_step;
`ifdef TANK_GRAVITY_EN
   logic [3:0] vel, vel_nxt;
   logic [4:0] vel_sum;
`endif

   x_dir_detect u_dir (
      .clk (frame_clk),
      .x   (bus.firstX),
      .dir (dir)
   );

   assign terr     = terrain_t'(bus.floor);
   assign ramp_cls = (terr == TERR_UP) || (terr == TERR_DOWN);
   assign climb    = ((terr == TERR_UP) && (dir == DIR_RIGHT)) || ((terr == TERR_DOWN) && (dir == DIR_LEFT));
   assign descend  = ((terr == TERR_DOWN) && (dir == DIR_RIGHT)) || ((terr == TERR_UP) && (dir == DIR_LEFT));

   assign y_w  = {1'b0, y};
   assign y_up = (y_w < ({1'b0, HIGH_Y} + {1'b0, CLIMB_STEP})) ? HIGH_Y : y - CLIMB_STEP;
   assign y_dn = ((y_w + {1'b0, CLIMB_STEP}) > {1'b0, LOW_Y}) ? LOW_Y : y + CLIMB_STEP;

`ifdef TANK_GRAVITY_EN
   assign vel_sum   = {1'b0, vel} + {1'b0, GRAVITY};
   assign fall_step = (vel_sum > {1'b0, MAX_FALL_V}) ? MAX_FALL_V : vel_sum[3:0];
`else
   assign fall_step = MAX_FALL_V;
`endif
   // Landing snaps to LOW_Y whatever velocity is left over.
   assign y_sum   = y_w + 11'(fall_step);
   assign y_fall  = (y_sum >= {1'b0, LOW_Y}) ? LOW_Y : y_sum[9:0];
   assign spawn_c = (bus.spawn_y > LOW_Y) ? LOW_Y : bus.spawn_y;

   always_comb begin
      state_nxt = state;
      y_nxt     = y;
`ifdef TANK_GRAVITY_EN
      vel_nxt   = vel;
`endif
      if (bus.spawn_req) begin
         y_nxt     = spawn_c;
         state_nxt = is_level(spawn_c) ? MS_GROUND : MS_FALL;
`ifdef TANK_GRAVITY_EN
         vel_nxt   = 4'd0;
`endif
      end else begin
         case (state)
            MS_GROUND: begin
               if (climb || descend) begin
                  state_nxt = MS_RAMP;
                  y_nxt     = climb ? y_up : y_dn;
               end else if (!ramp_cls && !is_level(y)) begin
                  state_nxt = MS_FALL;
`ifdef TANK_GRAVITY_EN
                  vel_nxt   = 4'd0;
`endif
               end
            end
            MS_RAMP: begin
               if (!ramp_cls) begin
                  state_nxt = is_level(y) ? MS_GROUND : MS_FALL;
`ifdef TANK_GRAVITY_EN
                  vel_nxt   = 4'd0;
`endif
               end else if (climb) begin
                  y_nxt = y_up;
               end else if (descend) begin
                  y_nxt = y_dn;
               end
            end
            MS_FALL: begin
               y_nxt = y_fall;
`ifdef TANK_GRAVITY_EN
               vel_nxt = (y_fall == LOW_Y) ? 4'd0 : fall_step;
`endif
               if (y_fall == LOW_Y) state_nxt = MS_GROUND;
            end
            default: state_nxt = MS_GROUND;
         endcase
      end
   end

   always_ff @(posedge frame_clk) begin
      if (!Reset) begin
         state        <= MS_GROUND;
         y            <= LOW_Y;
         bus.on_high  <= 1'b0;
         bus.airborne <= 1'b0;
`ifdef TANK_GRAVITY_EN
         vel          <= 4'd0;
`endif
      end else begin
         state        <= state_nxt;
         y            <= y_nxt;
         bus.on_high  <= (y_nxt == HIGH_Y) && (state_nxt == MS_GROUND);
         bus.airborne <= (state_nxt == MS_FALL);
`ifdef TANK_GRAVITY_EN
         vel          <= vel_nxt;
`endif
      end
   end

   assign bus.firstY = y;
   assign bus.mstate = state;
endmodule

// File: tb/tb_tank_vertical_motion.sv
// Directed and randomized checks of tank_vertical_motion against a behavioural model.
module tb_tank_vertical_motion;
   logic frame_clk = 1'b0;
   logic Reset;
   tank_vertical_motion_if bus ();

   tank_vertical_motion dut (
      .frame_clk (frame_clk),
      .Reset     (Reset),
      .bus       (bus)
   );

   always #5 frame_clk = ~frame_clk;

   int n_checks = 0;
   int n_fails  = 0;

   // model: state 0 ground, 1 ramp, 2 fall
   int m_y, m_st, m_vel, m_px;

   function automatic int imin(int a, int b); return (a < b) ? a : b; endfunction
   function automatic int imax(int a, int b); return (a > b) ? a : b; endfunction

   function automatic void model_step(int x, int fl, bit sp, int spy, bit rst_n);
      int d, cls;
      bit up_move, down_move, level;
      if (!rst_n) begin
         m_y = 400; m_st = 0; m_vel = 0; m_px = x;
         return;
      end
      d    = (x > m_px) ? 1 : (x < m_px) ? -1 : 0;
      m_px = x;
      cls  = (fl == 3) ? 0 : fl;
      if (sp) begin
         m_y   = imin(spy, 400);
         m_st  = (m_y == 400 || m_y == 380) ? 0 : 2;
         m_vel = 0;
         return;
      end
      up_move   = (cls == 2 && d == 1) || (cls == 1 && d == -1);
      down_move = (cls == 1 && d == 1) || (cls == 2 && d == -1);
      level     = (m_y == 400 || m_y == 380);
      if (m_st == 0) begin
         if (up_move || down_move) begin
            m_st = 1;
            m_y  = up_move ? imax(m_y - 1, 380) : imin(m_y + 1, 400);
         end else if (cls == 0 && !level) begin
            m_st = 2; m_vel = 0;
         end
      end else if (m_st == 1) begin
         if (cls == 0) begin
            m_st = level ? 0 : 2; m_vel = 0;
         end else if (up_move)   m_y = imax(m_y - 1, 380);
         else if (down_move)     m_y = imin(m_y + 1, 400);
      end else begin
`ifdef TANK_GRAVITY_EN
         m_vel = imin(m_vel + 1, 6);
`else
         m_vel = 6;
`endif
         m_y = imin(m_y + m_vel, 400);
         if (m_y == 400) begin m_st = 0; m_vel = 0; end
      end
   endfunction

   task automatic check(string tag);
      logic [9:0] ey;
      logic [1:0] es;
      ey = 10'(m_y);
      es = 2'(m_st);
      n_checks++;
      assert (bus.firstY === ey) else begin
         n_fails++;
         $error("FAIL %s firstY observed=%0d expected=%0d", tag, bus.firstY, ey);
      end
      n_checks++;
      assert (bus.mstate === es) else begin
         n_fails++;
         $error("FAIL %s mstate observed=%0d expected=%0d", tag, bus.mstate, es);
      end
      n_checks++;
      assert (bus.airborne === (m_st == 2)) else begin
         n_fails++;
         $error("FAIL %s airborne observed=%0b expected=%0b", tag, bus.airborne, (m_st == 2));
      end
      n_checks++;
      assert (bus.on_high === (m_st == 0 && m_y == 380)) else begin
         n_fails++;
         $error("FAIL %s on_high observed=%0b expected=%0b", tag, bus.on_high, (m_st == 0 && m_y == 380));
      end
   endtask

   task automatic cycle(int x, int fl, bit sp, int spy, bit rst_n, string tag);
      bus.firstX    = 10'(x);
      bus.floor     = 2'(fl);
      bus.spawn_req = sp;
      bus.spawn_y   = 10'(spy);
      Reset         = rst_n;
      @(posedge frame_clk);
      model_step(x, fl, sp, spy, rst_n);
      #1;
      check(tag);
   endtask

   task automatic expect_y(int y, string tag);
      logic [9:0] ey;
      ey = 10'(y);
      n_checks++;
      assert (bus.firstY === ey) else begin
         n_fails++;
         $error("FAIL %s firstY observed=%0d expected=%0d", tag, bus.firstY, ey);
      end
   endtask

   initial begin
      int x, fl, spy;
      bit sp, rn;
      bus.firstX = 10'd100; bus.floor = 2'd0; bus.spawn_req = 1'b0; bus.spawn_y = 10'd0;
      Reset = 1'b0;

      cycle(100, 0, 0, 0, 0, "reset1");
      cycle(100, 0, 0, 0, 0, "reset2");
      expect_y(400, "reset_y");

      cycle(30, 0, 0, 0, 1, "pre_climb");
      for (int i = 1; i <= 25; i++) cycle(30 + i, 2, 0, 0, 1, "climb");
      expect_y(380, "climb_sat");
      cycle(55, 0, 0, 0, 1, "climb_land");
      expect_y(380, "on_high_y");

      for (int i = 112; i <= 140; i++) cycle(i, 1, 0, 0, 1, "descend");
      expect_y(400, "descend_clamp");
      cycle(140, 0, 0, 0, 1, "descend_land");

      for (int i = 1; i <= 10; i++) cycle(140 + i, 2, 0, 0, 1, "to390");
      expect_y(390, "at390");
      for (int i = 0; i < 5; i++) cycle(150, 2, 0, 0, 1, "ramp_still");
      expect_y(390, "still390");

      cycle(150, 0, 0, 0, 1, "ramp_off");
`ifdef TANK_GRAVITY_EN
      cycle(150, 0, 0, 0, 1, "fall"); expect_y(391, "fall1");
      cycle(150, 0, 0, 0, 1, "fall"); expect_y(393, "fall2");
      cycle(150, 0, 0, 0, 1, "fall"); expect_y(396, "fall3");
      cycle(150, 0, 0, 0, 1, "fall"); expect_y(400, "fall4");
`else
      cycle(150, 0, 0, 0, 1, "fall"); expect_y(396, "fall1");
      cycle(150, 0, 0, 0, 1, "fall"); expect_y(400, "fall2");
`endif

      cycle(150, 3, 1, 200, 0, "reset_beats_spawn");
      expect_y(400, "reset_win_y");
      cycle(150, 2, 1, 200, 1, "spawn200");
      expect_y(200, "spawn_y");
      for (int i = 0; i < 100 && m_st != 0; i++) cycle(150, 0, 0, 0, 1, "spawn_fall");
      expect_y(400, "spawn_landed");
      cycle(150, 0, 1, 1000, 1, "spawn_clamp");
      cycle(150, 0, 1, 380, 1, "spawn_high");
      cycle(150, 0, 1, 200, 1, "spawn_again");
      cycle(150, 0, 0, 0, 1, "midfall");
      cycle(150, 0, 0, 0, 1, "midfall");
      cycle(150, 0, 0, 0, 0, "reset_midfall");
      expect_y(400, "reset_midfall_y");

      x = 300;
      for (int i = 0; i < 600; i++) begin
         x  = imin(imax(x + int'($urandom_range(0, 4)) - 2, 0), 639);
         fl = int'($urandom_range(0, 3));
         sp = ($urandom_range(0, 19) == 0);
         case ($urandom_range(0, 3))
            0:       spy = 380;
            1:       spy = 400;
            default: spy = int'($urandom_range(0, 1023));
         endcase
         rn = ($urandom_range(0, 49) != 0);
         cycle(x, fl, sp, spy, rn, "random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
